div_sequencer: RTL and testbench
================================

// Module: div_sequencer
// PURPOSE
//   Multi-cycle controller for MIPS DIV/DIVU. Owns the HI/LO register pair and sequences a 32-step
//   restoring divider. The single-cycle core issues a divide and continues executing. The block stalls the core
//   only when a later instruction touches HI/LO, or issues another divide, while a divide is in flight.
//   Sits beside the RF in the MIPS top; the control unit drives start/hilo_rd/wr_hi/wr_lo.
// PARAMETERS
//   WIDTH   32   operand/HI/LO width; iteration count = WIDTH
// PORTS
//   clk        in   1      core clock, rising edge
//   rst        in   1      asynchronous, active-high reset
//   start      in   1      DIV/DIVU issued this cycle
//   is_signed  in   1      1 = DIV, 0 = DIVU; sampled with start
//   dividend   in   WIDTH  rs value; sampled with start
//   divisor    in   WIDTH  rt value; sampled with start
//   hilo_rd    in   1      MFHI/MFLO this cycle
//   wr_hi      in   1      MTHI this cycle
//   wr_lo      in   1      MTLO this cycle
//   wdata      in   WIDTH  MTHI/MTLO data
//   hi         out  WIDTH  HI register (remainder)
//   lo         out  WIDTH  LO register (quotient)
//   busy       out  1      divide in flight (PREP..FIX)
//   done       out  1      1-cycle pulse: HI/LO updated by a divide
//   stall      out  1      core must hold PC/instruction this cycle
//   div_zero   out  1      only with DIV_ZERO_TRAP_EN; pulses with done
// BEHAVIOUR
//   Reset: state=IDLE, hi=lo=0, busy=done=stall=0, iteration counter=0; asserts mid-divide abort with no HI/LO write.
//   FSM states: IDLE -> PREP -> ITER (x WIDTH) -> FIX -> DONE -> IDLE.
//     Also DONE -> PREP directly when start is high in DONE.
//   IDLE/DONE + start: latch operands and sign flags, go to PREP. In PREP, take |x| when is_signed.
//     Use unsigned WIDTH-bit abs, so abs(0x80000000) = 0x80000000.
//   ITER: one restoring step per cycle: rem = {rem,q[MSB]} - divisor; keep if non-negative; shift q.
//     Counter runs WIDTH-1..0.
//   FIX: negate quotient if signs differ. Remainder takes the dividend's sign (truncate toward zero).
//     Write lo=quotient and hi=remainder at the FIX->DONE edge.
//   Latency: start sampled at edge T; done=1 in the cycle after edge T+WIDTH+2 (cycle 35 for WIDTH=32).
//   busy = state in {PREP,ITER,FIX}. stall = busy & (start | hilo_rd | wr_hi | wr_lo).
//     Stalled requests are ignored and re-presented by the core.
//   wr_hi/wr_lo with busy=0: write wdata at the edge. Allowed in DONE after the divide result is visible.
//   Divisor 0, macro off: result falls out of the algorithm.
//     DIVU: lo=0xFFFFFFFF, hi=dividend.
//     DIV: lo=0xFFFFFFFF if dividend>=0, else 0x00000001; hi=dividend.
//   0x80000000 / 0xFFFFFFFF signed -> lo=0x80000000, hi=0.
// CONFIGURATION
//   DIV_ZERO_TRAP_EN defined:
//     - divisor==0 at start: PREP goes straight to DONE (done in cycle 2), HI/LO unchanged.
//     - div_zero=1 with done.
//   DIV_ZERO_TRAP_EN undefined: no div_zero port; divide-by-zero runs the full sequence as above.
// STRUCTURE
//   Package mdu_pkg: state encoding localparams (IDLE,PREP,ITER,FIX,DONE), DIV_WIDTH=32, counter width clog2(WIDTH).
//   Sub-module div_step: combinational single restoring iteration (rem_in, q_in, divisor -> rem_out, q_out).
//   FSM, counter, HI/LO regs and sign fix-up stay in div_sequencer.
// TESTING
//   DIVU 100/7 -> done at cycle 35, lo=0x0000000E, hi=0x00000002, busy high cycles 1..34.
//   DIV -100/7 -> lo=0xFFFFFFF2, hi=0xFFFFFFFE; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
//   Start DIVU 9/2, hilo_rd at cycle 5 -> stall=1 cycles 5..34, stall=0 at 35 with lo=4, hi=1.
//   rst pulse at cycle 10 of a divide -> busy=0, hi=lo=0 immediately; next start completes normally.
//   DIVU 5/0: macro off -> lo=0xFFFFFFFF, hi=5 at cycle 35; macro on -> done+div_zero at cycle 2, hi/lo unchanged.
//   wr_hi 0x1234 while busy -> stall, hi unchanged; same write in IDLE -> hi=0x00001234 next cycle.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: divider width, counter width and FSM encoding.
// Used by div_sequencer (optional feature macro: DIV_ZERO_TRAP_EN).
package mdu_pkg;

  localparam int unsigned DIV_WIDTH = 32;
  localparam int unsigned DIV_CNT_W = $clog2(DIV_WIDTH);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] PREP = 3'd1;
  localparam logic [2:0] ITER = 3'd2;
  localparam logic [2:0] FIX  = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  typedef enum logic [2:0] {
    StIdle = IDLE,
    StPrep = PREP,
    StIter = ITER,
    StFix  = FIX,
    StDone = DONE
  } div_state_e;

endpackage

// File: rtl/div_sequencer_if.sv
// Core <-> divide sequencer interface: divide issue, HI/LO access and status/stall back to the core.
// The div_zero signal exists only when DIV_ZERO_TRAP_EN is defined.
interface div_sequencer_if #(
  parameter int unsigned WIDTH = mdu_pkg::DIV_WIDTH
) ();

  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             hilo_rd;
  logic             wr_hi;
  logic             wr_lo;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             stall;
`ifdef DIV_ZERO_TRAP_EN
  logic             div_zero;

  modport master (
    output start, is_signed, dividend, divisor, hilo_rd, wr_hi, wr_lo, wdata,
    input  hi, lo, busy, done, stall, div_zero
  );

  modport slave (
    input  start, is_signed, dividend, divisor, hilo_rd, wr_hi, wr_lo, wdata,
    output hi, lo, busy, done, stall, div_zero
  );
`else
  modport master (
    output start, is_signed, dividend, divisor, hilo_rd, wr_hi, wr_lo, wdata,
    input  hi, lo, busy, done, stall
  );

  modport slave (
    input  start, is_signed, dividend, divisor, hilo_rd, wr_hi, wr_lo, wdata,
    output hi, lo, busy, done, stall
  );
`endif

endinterface

// File: rtl/div_step.sv
// One combinational restoring-division step: shift the next quotient bit into the remainder,
// subtract the divisor and keep the difference only if it is non-negative.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] q_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] q_out
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  always_comb begin
    shifted = {rem_in, q_in[WIDTH-1]};
    trial   = shifted - {1'b0, divisor};
    // The shifted remainder is always below 2*divisor, so bit WIDTH of trial is the borrow.
    if (!trial[WIDTH]) begin
      rem_out = trial[WIDTH-1:0];
      q_out   = {q_in[WIDTH-2:0], 1'b1};
    end else begin
      rem_out = shifted[WIDTH-1:0];
      q_out   = {q_in[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_sequencer.sv
// MIPS DIV/DIVU sequencer: owns HI/LO, runs a WIDTH-step restoring divide and stalls the core on
// HI/LO hazards. Optional DIV_ZERO_TRAP_EN skips divide-by-zero and flags it on div_zero.
module div_sequencer
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input logic            clk,
  input logic            rst,
  div_sequencer_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  div_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic             dvd_neg_q;
  logic             dvs_neg_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             busy_q;
  logic             done_q;
`ifdef DIV_ZERO_TRAP_EN
  logic             div_zero_q;
`endif

  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_q;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  div_step #(
    .WIDTH (WIDTH)
  ) u_div_step (
    .rem_in  (rem_q),
    .q_in    (quo_q),
    .divisor (dvs_q),
    .rem_out (step_rem),
    .q_out   (step_q)
  );

  // Quotient truncates toward zero; remainder follows the dividend's sign.
  always_comb begin
    quo_fix = (dvd_neg_q ^ dvs_neg_q) ? -quo_q : quo_q;
    rem_fix = dvd_neg_q ? -rem_q : rem_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      dvd_neg_q  <= 1'b0;
      dvs_neg_q  <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef DIV_ZERO_TRAP_EN
      div_zero_q <= 1'b0;
`endif
    end else begin
      done_q     <= 1'b0;
`ifdef DIV_ZERO_TRAP_EN
      div_zero_q <= 1'b0;
`endif
      if (!busy_q && bus.wr_hi) hi_q <= bus.wdata;
      if (!busy_q && bus.wr_lo) lo_q <= bus.wdata;

      unique case (state_q)
        StIdle, StDone: begin
          if (bus.start) begin
            quo_q     <= bus.dividend;
            dvs_q     <= bus.divisor;
            dvd_neg_q <= bus.is_signed & bus.dividend[WIDTH-1];
            dvs_neg_q <= bus.is_signed & bus.divisor[WIDTH-1];
            busy_q    <= 1'b1;
            state_q   <= StPrep;
          end else begin
            state_q   <= StIdle;
          end
        end
        StPrep: begin
`ifdef DIV_ZERO_TRAP_EN
          if (dvs_q == '0) begin
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            div_zero_q <= 1'b1;
            state_q    <= StDone;
          end else begin
`else
          begin
`endif
            // Unsigned negate gives abs(most-negative) == most-negative, which the divider handles.
            quo_q   <= dvd_neg_q ? -quo_q : quo_q;
            dvs_q   <= dvs_neg_q ? -dvs_q : dvs_q;
            rem_q   <= '0;
            cnt_q   <= CNT_W'(WIDTH - 1);
            state_q <= StIter;
          end
        end
        StIter: begin
          rem_q <= step_rem;
          quo_q <= step_q;
          if (cnt_q == '0) begin
            state_q <= StFix;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StFix: begin
          hi_q    <= rem_fix;
          lo_q    <= quo_fix;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= StDone;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.stall = busy_q & (bus.start | bus.hilo_rd | bus.wr_hi | bus.wr_lo);
`ifdef DIV_ZERO_TRAP_EN
  assign bus.div_zero = div_zero_q;
`endif

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer: arithmetic reference model checked every cycle, plus
// hand-computed expectations per scenario. Honours DIV_ZERO_TRAP_EN like the design.
module tb_div_sequencer;
  import mdu_pkg::*;

  localparam int unsigned W = DIV_WIDTH;
`ifdef DIV_ZERO_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  div_sequencer_if #(.WIDTH(W)) bus ();

  div_sequencer #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference divide from magnitudes; divide-by-zero yields all-ones quotient, dividend remainder.
  task automatic ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r);
    longint unsigned ma, mb, mq, mr;
    bit na, nb;
    na = sgn && a[31];
    nb = sgn && b[31];
    ma = na ? (64'h1_0000_0000 - {32'b0, a}) : {32'b0, a};
    mb = nb ? (64'h1_0000_0000 - {32'b0, b}) : {32'b0, b};
    if (mb == 0) begin
      mq = 64'hFFFF_FFFF;
      mr = ma;
    end else begin
      mq = ma / mb;
      mr = ma % mb;
    end
    q = (na ^ nb) ? -mq[31:0] : mq[31:0];
    r = na ? -mr[31:0] : mr[31:0];
  endtask

  // Model state: age = cycles since the divide was accepted (0 = none in flight).
  int          age = 0;
  int          target = 0;
  bit          m_trap = 1'b0;
  bit          m_was_busy;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  logic        m_done = 1'b0, m_dz = 1'b0;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      age = 0; m_hi = '0; m_lo = '0; m_done = 1'b0; m_dz = 1'b0;
    end else begin
      m_was_busy = (age > 0);
      m_done = 1'b0;
      m_dz   = 1'b0;
      if (!m_was_busy && bus.wr_hi) m_hi = bus.wdata;
      if (!m_was_busy && bus.wr_lo) m_lo = bus.wdata;
      if (m_was_busy) begin
        age++;
        if (age == target) begin
          if (m_trap) m_dz = 1'b1;
          else begin
            m_hi = p_hi;
            m_lo = p_lo;
          end
          m_done = 1'b1;
          age = 0;
        end
      end else if (bus.start) begin
        ref_div(bus.is_signed, bus.dividend, bus.divisor, p_lo, p_hi);
        m_trap = TRAP && (bus.divisor == 0);
        target = m_trap ? 2 : W + 3;
        age = 1;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    check("cyc_busy", bus.busy, age > 0);
    check("cyc_done", bus.done, m_done);
    check("cyc_stall", bus.stall,
          (age > 0) && (bus.start || bus.hilo_rd || bus.wr_hi || bus.wr_lo));
    check("cyc_hi", bus.hi, m_hi);
    check("cyc_lo", bus.lo, m_lo);
`ifdef DIV_ZERO_TRAP_EN
    check("cyc_div_zero", bus.div_zero, m_dz);
`endif
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a divide for one cycle; returns in cycle 1 of the operation.
  task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1; bus.is_signed = sgn; bus.dividend = a; bus.divisor = b;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic finish_div(input string name, input int n0, input logic [31:0] e_lo,
                            input logic [31:0] e_hi, input int e_lat);
    int n;
    n = n0;
    while (!bus.done && n < 100) begin
      tick();
      n++;
    end
    check({name, "_latency"}, n, e_lat);
    check({name, "_lo"}, bus.lo, e_lo);
    check({name, "_hi"}, bus.hi, e_hi);
  endtask

  task automatic run_div(input string name, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] e_lo, input logic [31:0] e_hi,
                         input int e_lat);
    issue(sgn, a, b);
    check({name, "_busy1"}, bus.busy, 1);
    finish_div(name, 1, e_lo, e_hi, e_lat);
  endtask

  initial begin
    int n;
    logic [31:0] hi_prev;
    bus.start = 1'b0; bus.is_signed = 1'b0; bus.dividend = '0; bus.divisor = '0;
    bus.hilo_rd = 1'b0; bus.wr_hi = 1'b0; bus.wr_lo = 1'b0; bus.wdata = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_hi", bus.hi, 32'h0);
    check("reset_lo", bus.lo, 32'h0);
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);

    run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 32'h0000_000E, 32'h0000_0002, 35);
    tick();
    run_div("div_m100_7", 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 35);
    // Issued in the DONE cycle of the previous divide.
    run_div("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 35);
    tick();

    issue(1'b0, 32'd9, 32'd2);
    repeat (4) tick();
    bus.hilo_rd = 1'b1;
    #1;
    check("hilo_stall_c5", bus.stall, 1);
    n = 5;
    while (bus.stall && n < 100) begin
      tick();
      n++;
    end
    check("hilo_release_cycle", n, 35);
    check("hilo_lo", bus.lo, 32'd4);
    check("hilo_hi", bus.hi, 32'd1);
    bus.hilo_rd = 1'b0;
    tick();

    issue(1'b0, 32'd100, 32'd7);
    repeat (9) tick();
    rst = 1'b1;
    #1;
    check("abort_busy", bus.busy, 0);
    check("abort_hi", bus.hi, 32'h0);
    check("abort_lo", bus.lo, 32'h0);
    tick();
    rst = 1'b0;
    tick();
    run_div("after_rst", 1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 35);
    tick();

`ifdef DIV_ZERO_TRAP_EN
    run_div("divu_5_0", 1'b0, 32'd5, 32'd0, 32'd333, 32'd1, 2);
    check("divu_5_0_flag", bus.div_zero, 1);
    tick();
    run_div("div_m5_0", 1'b1, 32'hFFFF_FFFB, 32'd0, 32'd333, 32'd1, 2);
    hi_prev = 32'd1;
`else
    run_div("divu_5_0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 35);
    tick();
    run_div("div_m5_0", 1'b1, 32'hFFFF_FFFB, 32'd0, 32'h0000_0001, 32'hFFFF_FFFB, 35);
    hi_prev = 32'hFFFF_FFFB;
`endif

    bus.wr_lo = 1'b1; bus.wdata = 32'h0000_ABCD;
    tick();
    bus.wr_lo = 1'b0;
    check("done_wr_lo", bus.lo, 32'h0000_ABCD);

    issue(1'b1, 32'd7, 32'hFFFF_FFFE);
    tick();
    bus.wr_hi = 1'b1; bus.wdata = 32'h0000_1234;
    #1;
    check("busy_wr_stall", bus.stall, 1);
    tick();
    bus.wr_hi = 1'b0;
    check("busy_wr_hi_kept", bus.hi, hi_prev);
    finish_div("div_7_m2", 3, 32'hFFFF_FFFD, 32'd1, 35);
    tick();

    bus.wr_hi = 1'b1; bus.wdata = 32'h0000_1234;
    tick();
    bus.wr_hi = 1'b0;
    check("idle_wr_hi", bus.hi, 32'h0000_1234);
    check("idle_wr_lo_kept", bus.lo, 32'hFFFF_FFFD);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
